// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared hazard-control types: FSM states, register-zero, forward-select codes
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } hazard_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EX_MEM  = 2'b10;
  localparam logic [1:0] FWD_MEM_WB  = 2'b01;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_hold;
  } hazard_ctrl_t;

  // Free-running pipeline: fetch and decode advance, nothing squashed or held.
  function automatic hazard_ctrl_t ctrl_run();
    hazard_ctrl_t c;
    c              = '0;
    c.pc_write     = 1'b1;
    c.if_id_write  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between ID sources and EX load
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_memread,
  output logic       load_use
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = (id_ex_rd == id_rs1);
  assign rs2_match = id_uses_rs2 & (id_ex_rd == id_rs2);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = id_ex_memread & (id_ex_rd != REG_ZERO) & (rs1_match | rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush/memory-wait controller; HAZARD_PERF_CNT_EN adds perf counters
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_memread,
  input  logic       ex_branch_taken,
  input  logic       mem_busy,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_bubble,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_hold,
  output logic [1:0] state,
  output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] wait_cnt
`endif
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  hazard_state_e state_q;
  hazard_state_e state_next;
  hazard_ctrl_t  ctrl;
  logic [7:0]    wait_q;
  logic [7:0]    wait_next;
  logic          mem_timeout_q;
  logic          load_use;

  load_use_detect u_load_use_detect (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs2   (id_uses_rs2),
    .id_ex_rd      (id_ex_rd),
    .id_ex_memread (id_ex_memread),
    .load_use      (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_q        <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_next;
      wait_q  <= wait_next;
      if (mem_busy && (wait_next == TIMEOUT_LIM)) begin
        mem_timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    wait_next = 8'd0;
    if (mem_busy) begin
      wait_next = (wait_q == 8'hFF) ? 8'hFF : wait_q + 8'd1;
    end
  end

  // Priority is mem_busy > branch > load-use; stalled or squashed ID slots ignore load-use.
  always_comb begin
    ctrl       = ctrl_run();
    state_next = ST_RUN;
    if (rst) begin
      ctrl       = ctrl_run();
      state_next = ST_RUN;
    end else if (mem_busy) begin
      ctrl.pc_write    = 1'b0;
      ctrl.if_id_write = 1'b0;
      ctrl.ex_mem_hold = 1'b1;
      state_next       = ST_MEM_WAIT;
    end else if (ex_branch_taken) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      state_next       = ST_FLUSH;
    end else if (load_use && (state_q == ST_RUN || state_q == ST_MEM_WAIT)) begin
      ctrl.pc_write     = 1'b0;
      ctrl.if_id_write  = 1'b0;
      ctrl.id_ex_bubble = 1'b1;
      state_next        = ST_LOAD_STALL;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_hold  = ctrl.ex_mem_hold;
  assign state        = state_q;
  assign mem_timeout  = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
      wait_cnt  <= 32'd0;
    end else begin
      if (ctrl.id_ex_bubble) stall_cnt <= stall_cnt + 32'd1;
      if (ctrl.if_id_flush)  flush_cnt <= flush_cnt + 32'd1;
      if (ctrl.ex_mem_hold)  wait_cnt  <= wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl (HAZARD_PERF_CNT_EN optional)
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic       id_uses_rs2, id_ex_memread, ex_branch_taken, mem_busy;

  logic       pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_hold;
  logic [1:0] state;
  logic       mem_timeout;

  logic       to_pc_write, to_if_id_write, to_id_ex_bubble, to_if_id_flush, to_id_ex_flush, to_ex_mem_hold;
  logic [1:0] to_state;
  logic       to_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
  logic [31:0] to_stall_cnt, to_flush_cnt, to_wait_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_hold(ex_mem_hold), .state(state), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(3)) dut_to (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_write(to_pc_write), .if_id_write(to_if_id_write),
    .id_ex_bubble(to_id_ex_bubble), .if_id_flush(to_if_id_flush), .id_ex_flush(to_id_ex_flush),
    .ex_mem_hold(to_ex_mem_hold), .state(to_state), .mem_timeout(to_mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(to_stall_cnt), .flush_cnt(to_flush_cnt), .wait_cnt(to_wait_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; id_ex_rd = 5'd0;
    id_ex_memread = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    mem_busy = 1'b1;
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_if_id_write", 32'(if_id_write), 32'd1);
    chk("rst_ex_mem_hold", 32'(ex_mem_hold), 32'd0);
    chk("rst_mem_timeout", 32'(mem_timeout), 32'd0);

    mem_busy = 1'b0;
    rst = 1'b0;
    step();
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_pc_write", 32'(pc_write), 32'd1);

    // load-use on rs1
    id_ex_memread = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5;
    #1;
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_if_id_write", 32'(if_id_write), 32'd0);
    chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
    step();
    chk("lu_state_stall", 32'(state), 32'd1);
    chk("lu_stall_ignores_pc", 32'(pc_write), 32'd1);
    chk("lu_stall_ignores_bubble", 32'(id_ex_bubble), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_one", stall_cnt, 32'd1);
`endif
    step();
    chk("lu_state_run", 32'(state), 32'd0);
    clear_inputs();

    // x0 destination never stalls
    id_ex_memread = 1'b1; id_ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    chk("x0_bubble", 32'(id_ex_bubble), 32'd0);
    chk("x0_pc_write", 32'(pc_write), 32'd1);
    // rs2 match only counts when rs2 is used
    id_ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd3; id_uses_rs2 = 1'b0;
    #1;
    chk("rs2_unused_bubble", 32'(id_ex_bubble), 32'd0);
    id_uses_rs2 = 1'b1;
    #1;
    chk("rs2_used_bubble", 32'(id_ex_bubble), 32'd1);
    step();
    chk("rs2_state_stall", 32'(state), 32'd1);
    clear_inputs();
    step();
    chk("rs2_state_run", 32'(state), 32'd0);

    // branch beats load-use
    id_ex_memread = 1'b1; id_ex_rd = 5'd9; id_rs1 = 5'd9; ex_branch_taken = 1'b1;
    #1;
    chk("br_if_id_flush", 32'(if_id_flush), 32'd1);
    chk("br_id_ex_flush", 32'(id_ex_flush), 32'd1);
    chk("br_bubble", 32'(id_ex_bubble), 32'd0);
    chk("br_pc_write", 32'(pc_write), 32'd1);
    step();
    chk("br_state_flush", 32'(state), 32'd2);
    ex_branch_taken = 1'b0;
    #1;
    chk("flush_ignores_lu", 32'(id_ex_bubble), 32'd0);
    step();
    chk("flush_state_run", 32'(state), 32'd0);
    clear_inputs();

    // four-cycle memory wait
    mem_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("mw_hold_%0d", i), 32'(ex_mem_hold), 32'd1);
      chk($sformatf("mw_pc_write_%0d", i), 32'(pc_write), 32'd0);
      step();
      chk($sformatf("mw_state_%0d", i), 32'(state), 32'd3);
      chk($sformatf("mw_timeout255_%0d", i), 32'(mem_timeout), 32'd0);
      chk($sformatf("mw_timeout3_%0d", i), 32'(to_mem_timeout), (i >= 3) ? 32'd1 : 32'd0);
    end
    mem_busy = 1'b0;
    #1;
    chk("mw_release_hold", 32'(ex_mem_hold), 32'd0);
    step();
    chk("mw_release_state", 32'(state), 32'd0);

    // leaving MEM_WAIT into a load-use stall
    mem_busy = 1'b1;
    step();
    mem_busy = 1'b0; id_ex_memread = 1'b1; id_ex_rd = 5'd4; id_rs1 = 5'd4;
    #1;
    chk("mw_lu_bubble", 32'(id_ex_bubble), 32'd1);
    step();
    chk("mw_lu_state", 32'(state), 32'd1);
    clear_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    chk("mw_rst_timeout3", 32'(to_mem_timeout), 32'd0);

    // timeout at 3 with five busy cycles
    mem_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("to_flag_%0d", i), 32'(to_mem_timeout), (i >= 3) ? 32'd1 : 32'd0);
    end
    mem_busy = 1'b0;
    step();
    chk("to_sticky", 32'(to_mem_timeout), 32'd1);
    chk("to_state_run", 32'(to_state), 32'd0);
    rst = 1'b1;
    #2;
    chk("to_cleared_by_rst", 32'(to_mem_timeout), 32'd0);
    rst = 1'b0;
    step();

    // asynchronous reset mid-wait
    mem_busy = 1'b1;
    step();
    step();
    chk("ar_state_wait", 32'(state), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_hold", 32'(ex_mem_hold), 32'd0);
    chk("ar_pc_write", 32'(pc_write), 32'd1);
    chk("ar_if_id_write", 32'(if_id_write), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    chk("ar_stall_cnt", stall_cnt, 32'd0);
    chk("ar_flush_cnt", flush_cnt, 32'd0);
    chk("ar_wait_cnt", wait_cnt, 32'd0);
`endif
    mem_busy = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("ar_resume_state", 32'(state), 32'd0);
    chk("ar_resume_pc_write", 32'(pc_write), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
